// File: rtl/rule_packer_pkg.sv
// Shared helpers for the rule packer: configuration legality and the
// empty-byte count of an output word that ends a packet.
package rule_packer_pkg;

  localparam int unsigned MIN_RATIO = 2;

  function automatic bit cfg_ok(input int unsigned in_w, input int unsigned out_w);
    if (in_w == 0 || (in_w % 8) != 0) return 1'b0;
    return ((out_w % in_w) == 0) && ((out_w / in_w) >= MIN_RATIO);
  endfunction

  // Unused bytes when the last written lane is 'lane' and that beat carried in_empty.
  function automatic int unsigned eop_empty(input int unsigned lane, input int unsigned in_empty,
                                            input int unsigned ratio, input int unsigned in_w);
    return (ratio - 1 - lane) * (in_w / 8) + in_empty;
  endfunction

endpackage

// File: rtl/rule_packer_if.sv
// Narrow input stream, wide output stream and protocol status of the rule packer.
// master = surrounding logic (source + sink), slave = the packer.
interface rule_packer_if #(
  parameter int unsigned IN_W  = 128,
  parameter int unsigned OUT_W = 512
);
  localparam int unsigned IN_EW  = $clog2(IN_W / 8);
  localparam int unsigned OUT_EW = $clog2(OUT_W / 8);

  logic              in_sop;
  logic              in_eop;
  logic [IN_EW-1:0]  in_empty;
  logic              in_valid;
  logic [IN_W-1:0]   in_data;
  logic              in_ready;
  logic              out_sop;
  logic              out_eop;
  logic [OUT_EW-1:0] out_empty;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic              out_ready;
  logic              proto_err;

  modport master (
    output in_sop, in_eop, in_empty, in_valid, in_data, out_ready,
    input  in_ready, out_sop, out_eop, out_empty, out_valid, out_data, proto_err
  );

  modport slave (
    input  in_sop, in_eop, in_empty, in_valid, in_data, out_ready,
    output in_ready, out_sop, out_eop, out_empty, out_valid, out_data, proto_err
  );

endinterface

// File: rtl/rule_packer_out_reg.sv
// One-entry valid/ready register carrying a word with sop/eop/empty sideband.
// Used both as the output stage and as the pending slot behind it.
module rule_packer_out_reg #(
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned EMPTY_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid_i,
  input  logic [DATA_W-1:0]  s_data_i,
  input  logic               s_sop_i,
  input  logic               s_eop_i,
  input  logic [EMPTY_W-1:0] s_empty_i,
  input  logic               m_ready_i,
  output logic               m_valid_o,
  output logic [DATA_W-1:0]  m_data_o,
  output logic               m_sop_o,
  output logic               m_eop_o,
  output logic [EMPTY_W-1:0] m_empty_o
);

  logic               valid_q;
  logic [DATA_W-1:0]  data_q;
  logic               sop_q;
  logic               eop_q;
  logic [EMPTY_W-1:0] empty_q;
  logic               load_en;

  // The slot may take a new word whenever it is empty or its word is leaving.
  assign load_en = !valid_q || m_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      empty_q <= '0;
    end else if (load_en) begin
      valid_q <= s_valid_i;
      if (s_valid_i) begin
        data_q  <= s_data_i;
        sop_q   <= s_sop_i;
        eop_q   <= s_eop_i;
        empty_q <= s_empty_i;
      end
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign m_sop_o   = sop_q;
  assign m_eop_o   = eop_q;
  assign m_empty_o = empty_q;

endmodule

// File: rtl/rule_packer_gen.sv
// Width-up packer: gathers IN_W beats into OUT_W words, flushing on eop or a missing eop.
// Optional RULE_PACKER_STATS_EN adds stat_pkts/stat_beats output transfer counters.
module rule_packer_gen
  import rule_packer_pkg::*;
#(
  parameter int unsigned IN_W  = 128,
  parameter int unsigned OUT_W = 512
) (
  input  logic                clk,
  input  logic                rst,
  rule_packer_if.slave        bus
`ifdef RULE_PACKER_STATS_EN
  ,
  output logic [31:0]         stat_pkts,
  output logic [31:0]         stat_beats
`endif
);

  localparam int unsigned RATIO  = OUT_W / IN_W;
  localparam int unsigned OUT_EW = $clog2(OUT_W / 8);
  localparam int unsigned LW     = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

  if (!cfg_ok(IN_W, OUT_W)) begin : g_bad_cfg
    $error("rule_packer_gen: IN_W must be a multiple of 8 and OUT_W a multiple >= 2 of IN_W");
  end

  logic [LW-1:0]     lane_q, lane_d;
  logic [OUT_W-1:0]  acc_q, acc_d, word;
  logic              acc_sop_q, acc_sop_d;
  logic              in_pkt_q, in_pkt_d;
  logic              err_q, err_d;
  logic              in_ready, in_acc, flush, complete, out_s_ready;
  logic              o_s_valid, o_s_sop, o_s_eop;
  logic [OUT_W-1:0]  o_s_data;
  logic [OUT_EW-1:0] o_s_empty;
  logic              p_s_valid, p_valid, p_sop, p_eop;
  logic [OUT_W-1:0]  p_s_data, p_data;
  logic [OUT_EW-1:0] p_s_empty, p_empty;

  assign out_s_ready  = !bus.out_valid || bus.out_ready;
  assign in_ready     = out_s_ready && !p_valid;
  assign bus.in_ready = in_ready;
  assign in_acc       = bus.in_valid && in_ready;

  always_comb begin
    word      = acc_q | (OUT_W'(bus.in_data) << (lane_q * IN_W));
    flush     = in_acc && bus.in_sop && in_pkt_q && (lane_q != '0);
    complete  = in_acc && ((lane_q == LAST_LANE) || bus.in_eop);
    lane_d    = lane_q;
    acc_d     = acc_q;
    acc_sop_d = acc_sop_q;
    in_pkt_d  = in_pkt_q;
    err_d     = err_q;
    o_s_valid = 1'b0;
    o_s_data  = word;
    o_s_sop   = acc_sop_q || bus.in_sop;
    o_s_eop   = bus.in_eop;
    o_s_empty = bus.in_eop ? OUT_EW'(eop_empty(32'(lane_q), 32'(bus.in_empty), RATIO, IN_W)) : '0;
    p_s_valid = 1'b0;
    p_s_data  = OUT_W'(bus.in_data);
    p_s_empty = OUT_EW'(eop_empty(0, 32'(bus.in_empty), RATIO, IN_W));
    if (in_acc) begin
      if (bus.in_sop && in_pkt_q) err_d = 1'b1;
      if (bus.in_eop) in_pkt_d = 1'b0;
      else if (bus.in_sop) in_pkt_d = 1'b1;
      if (flush) begin
        // Close the orphaned partial word; the sop beat starts a fresh word,
        // parked in the pending slot if it is also a complete packet.
        o_s_valid = 1'b1;
        o_s_data  = acc_q;
        o_s_sop   = acc_sop_q;
        o_s_eop   = 1'b1;
        o_s_empty = OUT_EW'(eop_empty(32'(lane_q) - 32'd1, 0, RATIO, IN_W));
        p_s_valid = bus.in_eop;
        acc_d     = bus.in_eop ? '0 : OUT_W'(bus.in_data);
        lane_d    = bus.in_eop ? '0 : LW'(1);
        acc_sop_d = !bus.in_eop;
      end else if (complete) begin
        o_s_valid = 1'b1;
        lane_d    = '0;
        acc_d     = '0;
        acc_sop_d = 1'b0;
      end else begin
        acc_d     = word;
        lane_d    = lane_q + 1'b1;
        acc_sop_d = acc_sop_q || bus.in_sop;
      end
    end
    if (p_valid) begin
      o_s_valid = 1'b1;
      o_s_data  = p_data;
      o_s_sop   = p_sop;
      o_s_eop   = p_eop;
      o_s_empty = p_empty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q    <= '0;
      acc_q     <= '0;
      acc_sop_q <= 1'b0;
      in_pkt_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      lane_q    <= lane_d;
      acc_q     <= acc_d;
      acc_sop_q <= acc_sop_d;
      in_pkt_q  <= in_pkt_d;
      err_q     <= err_d;
    end
  end

  assign bus.proto_err = err_q;

  rule_packer_out_reg #(.DATA_W(OUT_W), .EMPTY_W(OUT_EW)) u_out (
    .clk       (clk),
    .rst       (rst),
    .s_valid_i (o_s_valid),
    .s_data_i  (o_s_data),
    .s_sop_i   (o_s_sop),
    .s_eop_i   (o_s_eop),
    .s_empty_i (o_s_empty),
    .m_ready_i (bus.out_ready),
    .m_valid_o (bus.out_valid),
    .m_data_o  (bus.out_data),
    .m_sop_o   (bus.out_sop),
    .m_eop_o   (bus.out_eop),
    .m_empty_o (bus.out_empty)
  );

  rule_packer_out_reg #(.DATA_W(OUT_W), .EMPTY_W(OUT_EW)) u_pend (
    .clk       (clk),
    .rst       (rst),
    .s_valid_i (p_s_valid),
    .s_data_i  (p_s_data),
    .s_sop_i   (1'b1),
    .s_eop_i   (1'b1),
    .s_empty_i (p_s_empty),
    .m_ready_i (out_s_ready),
    .m_valid_o (p_valid),
    .m_data_o  (p_data),
    .m_sop_o   (p_sop),
    .m_eop_o   (p_eop),
    .m_empty_o (p_empty)
  );

`ifdef RULE_PACKER_STATS_EN
  logic [31:0] pkts_q, beats_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkts_q  <= '0;
      beats_q <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      beats_q <= beats_q + 32'd1;
      if (bus.out_eop) pkts_q <= pkts_q + 32'd1;
    end
  end

  assign stat_pkts  = pkts_q;
  assign stat_beats = beats_q;
`endif

endmodule

// File: tb/tb_rule_packer_gen.sv
// Directed + randomized bench for rule_packer_gen against a packet-level queue model.
module tb_rule_packer_gen;

  localparam int IN_W  = 128;
  localparam int OUT_W = 512;
  localparam int RATIO = OUT_W / IN_W;
  localparam int IN_B  = IN_W / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rule_packer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

`ifdef RULE_PACKER_STATS_EN
  logic [31:0] stat_pkts, stat_beats;
`endif

  rule_packer_gen #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef RULE_PACKER_STATS_EN
    ,
    .stat_pkts  (stat_pkts),
    .stat_beats (stat_beats)
`endif
  );

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             sop;
    logic             eop;
    logic [5:0]       empty;
  } word_t;

  word_t           sb[$];
  word_t           last_out;
  logic [IN_W-1:0] cur[$];
  bit              cur_first, m_open, m_err, last_acc;
  int              m_pkts, m_beats, n_out, rdy_mode;
  int              checks = 0;
  int              failures = 0;

  task automatic chk(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] rand_beat();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Model: a word is the list of beats gathered so far, lane i = i-th beat.
  task automatic emit(input bit s, input bit e, input int emp);
    word_t w;
    w.data = '0;
    foreach (cur[i]) w.data[i*IN_W +: IN_W] = cur[i];
    w.sop = s;
    w.eop = e;
    w.empty = 6'(emp);
    sb.push_back(w);
    cur.delete();
    cur_first = 1'b0;
  endtask

  task automatic model_accept(input logic [IN_W-1:0] d, input logic s, input logic e, input logic [3:0] emp);
    if (s && m_open) begin
      m_err = 1'b1;
      if (cur.size() > 0) emit(cur_first, 1'b1, (RATIO - cur.size()) * IN_B);
    end
    cur.push_back(d);
    if (s) cur_first = 1'b1;
    if (e || cur.size() == RATIO) emit(cur_first, e, e ? (RATIO - cur.size()) * IN_B + int'(emp) : 0);
    if (e) m_open = 1'b0;
    else if (s) m_open = 1'b1;
  endtask

  task automatic model_reset();
    sb.delete();
    cur.delete();
    cur_first = 1'b0;
    m_open = 1'b0;
    m_err = 1'b0;
    m_pkts = 0;
    m_beats = 0;
  endtask

  task automatic step();
    logic er;
    @(negedge clk);
    last_acc = 1'b0;
    if (!rst) begin
      er = (sb.size() == 0) ? 1'b1 : (sb.size() == 1) ? bus.out_ready : 1'b0;
      chk("out_valid", 512'(bus.out_valid), 512'(sb.size() != 0));
      chk("in_ready", 512'(bus.in_ready), 512'(er));
      chk("proto_err", 512'(bus.proto_err), 512'(m_err));
`ifdef RULE_PACKER_STATS_EN
      chk("stat_pkts", 512'(stat_pkts), 512'(m_pkts));
      chk("stat_beats", 512'(stat_beats), 512'(m_beats));
`endif
      if (bus.out_valid && sb.size() != 0) begin
        chk("out_data", bus.out_data, sb[0].data);
        chk("out_sop", 512'(bus.out_sop), 512'(sb[0].sop));
        chk("out_eop", 512'(bus.out_eop), 512'(sb[0].eop));
        chk("out_empty", 512'(bus.out_empty), 512'(sb[0].empty));
        if (bus.out_ready) begin
          last_out.data  = bus.out_data;
          last_out.sop   = bus.out_sop;
          last_out.eop   = bus.out_eop;
          last_out.empty = bus.out_empty;
          void'(sb.pop_front());
          n_out++;
          m_beats++;
          if (last_out.eop) m_pkts++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        last_acc = 1'b1;
        model_accept(bus.in_data, bus.in_sop, bus.in_eop, bus.in_empty);
      end
    end
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = ~bus.out_ready;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic send_beat(input logic [IN_W-1:0] d, input logic s, input logic e, input logic [3:0] emp);
    bus.in_data  = d;
    bus.in_sop   = s;
    bus.in_eop   = e;
    bus.in_empty = emp;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      step();
      if (last_acc) break;
    end
    chk("accept", 512'(last_acc), 512'(1));
  endtask

  task automatic send_pkt(input int n, input logic [3:0] emp, input bit drop_eop);
    for (int i = 0; i < n; i++)
      send_beat(rand_beat(), i == 0, (i == n - 1) && !drop_eop, (i == n - 1) ? emp : 4'd0);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
    repeat (n) step();
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int n = 0; n < 60 && sb.size() != 0; n++) step();
    chk("drain", 512'(sb.size()), 512'(0));
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_sop    = 1'b0;
    bus.in_eop    = 1'b0;
    bus.in_empty  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    model_reset();
    rst = 1'b0;
    chk("rst_out_valid", 512'(bus.out_valid), 512'(0));
    chk("rst_out_data", bus.out_data, 512'(0));
    chk("rst_out_sop_eop", 512'({bus.out_sop, bus.out_eop}), 512'(0));
    chk("rst_out_empty", 512'(bus.out_empty), 512'(0));
    chk("rst_proto_err", 512'(bus.proto_err), 512'(0));
    chk("rst_in_ready", 512'(bus.in_ready), 512'(1));
`ifdef RULE_PACKER_STATS_EN
    chk("rst_stat_pkts", 512'(stat_pkts), 512'(0));
    chk("rst_stat_beats", 512'(stat_beats), 512'(0));
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rdy_mode = 0;
    n_out = 0;
    do_reset();

    // 8-beat packet at full rate: two words, sop then eop
    send_pkt(8, 4'd0, 1'b0);
    idle(2);
    chk("t1_words", 512'(n_out), 512'(2));
    chk("t1_last", 512'({last_out.sop, last_out.eop, last_out.empty}), 512'({1'b0, 1'b1, 6'd0}));

    // 5-beat packet ending with empty 3: second word holds one lane
    n_out = 0;
    send_pkt(5, 4'd3, 1'b0);
    idle(2);
    chk("t2_words", 512'(n_out), 512'(2));
    chk("t2_empty", 512'(last_out.empty), 512'(51));
    chk("t2_hi_zero", 512'(last_out.data[OUT_W-1:IN_W]), 512'(0));

    // single-beat packet, empty 15
    send_pkt(1, 4'd15, 1'b0);
    idle(2);
    chk("t3_single", 512'({last_out.sop, last_out.eop, last_out.empty}), 512'({1'b1, 1'b1, 6'd63}));

    // back-to-back 4-beat packets under a toggling sink
    rdy_mode = 1;
    repeat (3) send_pkt(4, 4'($urandom()), 1'b0);
    drain();
    rdy_mode = 0;
    bus.out_ready = 1'b1;

    // sop at lane 2 of an open packet: flush with empty 32, fresh packet continues
    send_beat(rand_beat(), 1'b1, 1'b0, 4'd0);
    send_beat(rand_beat(), 1'b0, 1'b0, 4'd0);
    send_beat(rand_beat(), 1'b1, 1'b0, 4'd0);
    idle(1);
    chk("t5_err", 512'(bus.proto_err), 512'(1));
    chk("t5_flush", 512'({last_out.sop, last_out.eop, last_out.empty}), 512'({1'b1, 1'b1, 6'd32}));
    send_beat(rand_beat(), 1'b0, 1'b0, 4'd0);
    send_beat(rand_beat(), 1'b0, 1'b1, 4'd5);
    idle(2);
    chk("t5_newpkt", 512'({last_out.sop, last_out.eop, last_out.empty}), 512'({1'b1, 1'b1, 6'd21}));

    // missing eop where the new sop is itself a whole packet: pending slot in use
    send_beat(rand_beat(), 1'b1, 1'b0, 4'd0);
    send_beat(rand_beat(), 1'b0, 1'b0, 4'd0);
    send_beat(rand_beat(), 1'b1, 1'b1, 4'd7);
    send_beat(rand_beat(), 1'b1, 1'b1, 4'd0);
    drain();
    chk("t5_pend_last", 512'({last_out.sop, last_out.eop, last_out.empty}), 512'({1'b1, 1'b1, 6'd48}));

    // missing eop at a word boundary: error only, no flush
    send_pkt(4, 4'd0, 1'b1);
    send_pkt(2, 4'd2, 1'b0);
    drain();

    // reset in the middle of a packet discards it
    send_beat(rand_beat(), 1'b1, 1'b0, 4'd0);
    send_beat(rand_beat(), 1'b0, 1'b0, 4'd0);
    send_beat(rand_beat(), 1'b0, 1'b0, 4'd0);
    do_reset();
    n_out = 0;
    send_pkt(2, 4'd9, 1'b0);
    idle(2);
    chk("t6_words", 512'(n_out), 512'(1));
    chk("t6_pkt", 512'({last_out.sop, last_out.eop, last_out.empty}), 512'({1'b1, 1'b1, 6'd41}));

    // random traffic, random sink, occasional missing eop
    rdy_mode = 2;
    repeat (40) begin
      send_pkt(int'($urandom_range(1, 10)), 4'($urandom()), $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
